// File: rtl/e_s_mmio.sv
// Memory-mapped I/O block: a 16-byte register window at the top of the CPU
// address space. It holds output channel registers, debounced input
// channels, sticky change events, an interrupt mask and an ID register.
module e_s_mmio #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int N_OUT      = 2,
  parameter int N_IN       = 2,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    we,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ce,
  input  logic [N_IN*DATA_W-1:0]  botones,
  output logic [N_OUT*DATA_W-1:0] leds,
  output logic                    irq
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // The counter loads on the DEB_CYCLES-th differing edge, so it only ever
  // reaches DEB_CYCLES-1 before clearing.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [15:0] ID_RAW = {8'(N_OUT), 8'(N_IN)};
  localparam logic [DATA_W-1:0] ID_VAL = DATA_W'(ID_RAW);

  localparam logic [3:0] OFF_STATUS = 4'd12;
  localparam logic [3:0] OFF_MASK   = 4'd13;
  localparam logic [3:0] OFF_ID     = 4'd14;

  logic            sel;
  logic [3:0]      off;
  logic            wr;

  logic [DATA_W-1:0] out_reg   [N_OUT];
  logic [DATA_W-1:0] sync1_reg [N_IN];
  logic [DATA_W-1:0] sync2_reg [N_IN];
  logic [DATA_W-1:0] deb_reg   [N_IN];
  logic [CW-1:0]     cnt_reg   [N_IN];

  logic [N_IN-1:0] deb_load;
  logic [N_IN-1:0] status_reg;
  logic [N_IN-1:0] mask_reg;
  logic [N_IN-1:0] w1c;
  logic            irq_reg;

  assign sel = &addr[ADDR_W-1:4];
  assign ce  = ~sel;
  assign off = addr[3:0];
  assign wr  = sel & we;

  genvar gi;

  // Output channel registers, one per implemented OUT offset.
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_out
      // Capture CPU writes addressed to this channel.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_reg[gi] <= '0;
        end else if (wr && off == 4'(gi)) begin
          out_reg[gi] <= wdata;
        end
      end
      assign leds[gi*DATA_W +: DATA_W] = out_reg[gi];
    end
  endgenerate

  // Input channels: two-flop synchronizer followed by a stability counter.
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in
      assign deb_load[gi] = (sync2_reg[gi] != deb_reg[gi]) && (cnt_reg[gi] == CNT_LAST);

      // Synchronize the pin and accept it once it differs for DEB_CYCLES edges.
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg[gi] <= '0;
          sync2_reg[gi] <= '0;
          deb_reg[gi]   <= '0;
          cnt_reg[gi]   <= '0;
        end else begin
          sync1_reg[gi] <= botones[gi*DATA_W +: DATA_W];
          sync2_reg[gi] <= sync1_reg[gi];
          if (sync2_reg[gi] != deb_reg[gi]) begin
            if (cnt_reg[gi] == CNT_LAST) begin
              deb_reg[gi] <= sync2_reg[gi];
              cnt_reg[gi] <= '0;
            end else begin
              cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
          end else begin
            cnt_reg[gi] <= '0;
          end
        end
      end
    end
  endgenerate

  assign w1c = (wr && off == OFF_STATUS) ? wdata[N_IN-1:0] : '0;

  // Sticky events (a new event beats a same-edge clear), mask and registered irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_reg <= '0;
      mask_reg   <= '0;
      irq_reg    <= 1'b0;
    end else begin
      status_reg <= (status_reg & ~w1c) | deb_load;
      if (wr && off == OFF_MASK) begin
        mask_reg <= wdata[N_IN-1:0];
      end
      irq_reg <= |(status_reg & mask_reg);
    end
  end

  assign irq = irq_reg;

  // Read mux; unimplemented offsets and accesses outside the window return 0.
  always_comb begin
    rdata = '0;
    if (sel) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (off == 4'(k)) rdata = out_reg[k];
      end
      for (int k = 0; k < N_IN; k++) begin
        if (off == 4'(k + 8)) rdata = deb_reg[k];
      end
      case (off)
        OFF_STATUS: rdata = DATA_W'(status_reg);
        OFF_MASK:   rdata = DATA_W'(mask_reg);
        OFF_ID:     rdata = ID_VAL;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_s_mmio.sv
// Self-checking bench for e_s_mmio: directed scenarios for the register map,
// debounce timing and interrupt behaviour, then randomized bus and pin
// traffic compared every cycle against a behavioural model.
module tb_e_s_mmio;

  localparam int DW  = 16;
  localparam int DEB = 4;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ce;
  logic [31:0] botones;
  logic [31:0] leds;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [15:0] m_out [2];
  logic [15:0] m_s1  [2];
  logic [15:0] m_s2  [2];
  logic [15:0] m_deb [2];
  int          m_run [2];
  logic [1:0]  m_status;
  logic [1:0]  m_mask;
  logic        m_irq;

  e_s_mmio #(
    .DATA_W(DW), .ADDR_W(16), .N_OUT(2), .N_IN(2), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .ce(ce), .botones(botones), .leds(leds), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    int o;
    o = int'(a[3:0]);
    if (a[15:4] != 12'hFFF) return 16'h0;
    if (o < 2) return m_out[o];
    if (o >= 8 && o < 10) return m_deb[o-8];
    if (o == 12) return {14'b0, m_status};
    if (o == 13) return {14'b0, m_mask};
    if (o == 14) return 16'h0202;
    return 16'h0;
  endfunction

  // Apply one clock edge to the model using the inputs presented before it.
  task automatic model_edge();
    logic [1:0] set;
    logic [1:0] clr;
    logic       nirq;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_out[k] = '0; m_s1[k] = '0; m_s2[k] = '0; m_deb[k] = '0; m_run[k] = 0;
      end
      m_status = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      nirq = |(m_status & m_mask);
      set  = '0;
      clr  = '0;
      for (int k = 0; k < 2; k++) begin
        if (m_s2[k] != m_deb[k]) begin
          m_run[k]++;
          if (m_run[k] == DEB) begin
            m_deb[k] = m_s2[k];
            m_run[k] = 0;
            set[k]   = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = botones[k*16 +: 16];
      end
      if (addr[15:4] == 12'hFFF && we) begin
        if (addr[3:0] < 4'd2) m_out[addr[0]] = wdata;
        else if (addr[3:0] == 4'd12) clr = wdata[1:0];
        else if (addr[3:0] == 4'd13) m_mask = wdata[1:0];
      end
      m_status = (m_status & ~clr) | set;
      m_irq    = nirq;
    end
  endtask

  task automatic step();
    if (we && addr[15:4] == 12'hFFF && !reset)
      $display("[%0t] write off=%0d data=%h", $time, addr[3:0], wdata);
    @(posedge clk);
    model_edge();
    #1;
    chk("leds", leds, {m_out[1], m_out[0]});
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("rdata", {16'b0, rdata}, {16'b0, m_read(addr)});
    chk("ce", {31'b0, ce}, {31'b0, addr[15:4] != 12'hFFF});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; we = 1'b1; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr = a; we = 1'b0;
    #1;
    chk(tag, {16'b0, rdata}, {16'b0, exp});
  endtask

  initial begin
    reset = 1'b1; addr = '0; we = 1'b0; wdata = '0; botones = '0;
    step(); step();
    reset = 1'b0;

    // Reset state
    rd(16'hFFF0, 16'h0000, "rst_out0");
    rd(16'hFFF1, 16'h0000, "rst_out1");
    rd(16'hFFFC, 16'h0000, "rst_status");
    rd(16'hFFFD, 16'h0000, "rst_mask");
    rd(16'hFFFE, 16'h0202, "rst_id");
    chk("rst_irq", {31'b0, irq}, 32'h0);

    // OUT[1] write
    addr = 16'hFFF1; we = 1'b1; wdata = 16'hA5A5;
    #1 chk("ce_window", {31'b0, ce}, 32'h0);
    step(); we = 1'b0;
    chk("leds_hi", {16'b0, leds[31:16]}, 32'h0000A5A5);
    chk("leds_lo", {16'b0, leds[15:0]}, 32'h0);
    rd(16'hFFF1, 16'hA5A5, "rd_out1");

    // Access outside the window
    addr = 16'h1234; we = 1'b1; wdata = 16'hFFFF;
    #1 chk("ce_outside", {31'b0, ce}, 32'h1);
    chk("rdata_outside", {16'b0, rdata}, 32'h0);
    step(); we = 1'b0;
    chk("leds_outside", leds, 32'hA5A5_0000);
    rd(16'hFFF6, 16'h0000, "rd_unimpl_out");
    rd(16'hFFFB, 16'h0000, "rd_unimpl_in");
    rd(16'hFFFF, 16'h0000, "rd_reserved");

    // Mask on, then a glitch that must be rejected
    wr(16'hFFFD, 16'h0001);
    botones[15:0] = 16'h0001;
    addr = 16'hFFF8;
    repeat (3) step();
    botones[15:0] = 16'h0000;
    repeat (8) step();
    rd(16'hFFF8, 16'h0000, "glitch_in0");
    rd(16'hFFFC, 16'h0000, "glitch_status");
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // Clean step: IN[0] updates exactly 6 edges later
    botones[15:0] = 16'h0003;
    addr = 16'hFFF8;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("step_in0_wait", {16'b0, rdata}, 32'h0);
    end
    step();
    chk("step_in0", {16'b0, rdata}, 32'h0003);
    rd(16'hFFFC, 16'h0001, "step_status");
    chk("step_irq_lag", {31'b0, irq}, 32'h0);
    step();
    chk("step_irq", {31'b0, irq}, 32'h1);

    // Set wins over a same-edge W1C
    wr(16'hFFFC, 16'h0001);
    botones[15:0] = 16'h0000;
    addr = 16'hFFFC;
    repeat (5) step();
    we = 1'b1; wdata = 16'h0001;
    step(); we = 1'b0;
    rd(16'hFFFC, 16'h0001, "setwins_status");
    rd(16'hFFF8, 16'h0000, "setwins_in0");
    wr(16'hFFFC, 16'h0001);
    rd(16'hFFFC, 16'h0000, "w1c_status");
    chk("w1c_irq_hold", {31'b0, irq}, 32'h1);
    step();
    chk("w1c_irq_drop", {31'b0, irq}, 32'h0);

    // Reset in the middle of a debounce
    wr(16'hFFFD, 16'h0003);
    botones[31:16] = 16'h0001;
    repeat (6) step();
    rd(16'hFFFC, 16'h0002, "pre_rst_status");
    botones[15:0] = 16'h0005;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd(16'hFFF1, 16'h0000, "mid_rst_out1");
    rd(16'hFFF9, 16'h0000, "mid_rst_in1");
    rd(16'hFFFC, 16'h0000, "mid_rst_status");
    rd(16'hFFFD, 16'h0000, "mid_rst_mask");
    rd(16'hFFFE, 16'h0202, "mid_rst_id");
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    chk("mid_rst_leds", leds, 32'h0);
    addr = 16'hFFF8;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_wait", {16'b0, rdata}, 32'h0);
    end
    step();
    chk("post_rst_in0", {16'b0, rdata}, 32'h0005);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) != 0) addr = {12'hFFF, 4'($urandom_range(0, 15))};
      else addr = 16'($urandom);
      we    = 1'($urandom_range(0, 1));
      wdata = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) botones[15:0] = 16'($urandom);
        else botones[31:16] = 16'($urandom);
      end
      step();
    end
    reset = 1'b0; we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
